// File: rtl/mem_access_master_if.sv
// Request / write-data / read-data channels between bus-side logic and mem_access_master.
// No logic; carries the valid/ready handshakes plus the done and err pulses.
// master = upstream requester, slave = mem_access_master.
interface mem_access_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;

    logic              done;
    logic              err;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata,
        output rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata,
        input  rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err
    );
endinterface

// File: rtl/mem_access_master.sv
// Burst sequencer driving a single-port synchronous memory from a request channel.
// Latency: write beats pass straight to the memory pins; reads take RD_LAT+2 cycles per beat; done/err one cycle after the burst.
// Backpressure: wdata_valid gaps pause writes, rdata_ready low holds rdata; build macro MEM_READBACK_VERIFY_EN re-reads every written word.
module mem_access_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_master_if.slave bus,
    output logic               mem_write_enable,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data_in,
    input  logic [DATA_W-1:0]  mem_data_out
);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEAT  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
`ifdef MEM_READBACK_VERIFY_EN
        RD_RESP  = 3'd4,
        VF_ISSUE = 3'd5,
        VF_WAIT  = 3'd6
`else
        RD_RESP  = 3'd4
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [LEN_W-1:0]  beats_left;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              err_q;
`ifdef MEM_READBACK_VERIFY_EN
    logic [DATA_W-1:0] wdata_q;
`endif

    logic              req_oob;
    logic              last_beat;
    logic              lat_done;
    logic [ADDR_W-1:0] cur_next;

    assign req_oob   = {1'b0, bus.req_addr} >= DEPTH_EXT;
    assign last_beat = (beats_left == '0);
    assign lat_done  = (lat_cnt == LAT_LAST);
    // Bursts wrap inside the array so no address >= DEPTH is ever driven.
    assign cur_next  = (cur == ADDR_LAST) ? '0 : cur + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.req_valid && !req_oob)
                          state_nxt = bus.req_write ? WR_BEAT : RD_ISSUE;
`ifdef MEM_READBACK_VERIFY_EN
            WR_BEAT:  if (bus.wdata_valid) state_nxt = VF_ISSUE;
            VF_ISSUE: state_nxt = VF_WAIT;
            VF_WAIT:  if (lat_done) state_nxt = last_beat ? IDLE : WR_BEAT;
`else
            WR_BEAT:  if (bus.wdata_valid && last_beat) state_nxt = IDLE;
`endif
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (lat_done) state_nxt = RD_RESP;
            RD_RESP:  if (bus.rdata_ready) state_nxt = last_beat ? IDLE : RD_ISSUE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Burst address, beat/latency counters, read data and the done/err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            beats_left <= '0;
            lat_cnt    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_READBACK_VERIFY_EN
            wdata_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (bus.req_valid) begin
                        cur        <= bus.req_addr;
                        beats_left <= bus.req_len;
                        if (req_oob) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                WR_BEAT: begin
                    if (bus.wdata_valid) begin
`ifdef MEM_READBACK_VERIFY_EN
                        wdata_q <= bus.wdata;
`else
                        if (last_beat) begin
                            done_q <= 1'b1;
                        end else begin
                            cur        <= cur_next;
                            beats_left <= beats_left - 1'b1;
                        end
`endif
                    end
                end
`ifdef MEM_READBACK_VERIFY_EN
                VF_ISSUE: lat_cnt <= '0;
                VF_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) begin
                        if (mem_data_out != wdata_q) err_q <= 1'b1;
                        if (last_beat) begin
                            done_q <= 1'b1;
                        end else begin
                            cur        <= cur_next;
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
`endif
                RD_ISSUE: lat_cnt <= '0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) rdata_q <= mem_data_out;
                end
                RD_RESP: begin
                    if (bus.rdata_ready) begin
                        if (last_beat) begin
                            done_q <= 1'b1;
                        end else begin
                            cur        <= cur_next;
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs and memory pins; the write strobe is held off while reset is asserted.
    always_comb begin
        bus.req_ready    = (state == IDLE);
        bus.wdata_ready  = (state == WR_BEAT);
        bus.rdata_valid  = (state == RD_RESP);
        bus.rdata_last   = (state == RD_RESP) && last_beat;
        bus.rdata        = rdata_q;
        bus.done         = done_q;
        bus.err          = err_q;
        mem_write_enable = (state == WR_BEAT) && bus.wdata_valid && !reset;
        mem_data_in      = (state == WR_BEAT) ? bus.wdata : '0;
        mem_address      = '0;
        case (state)
            WR_BEAT, RD_ISSUE, RD_WAIT: mem_address = cur;
`ifdef MEM_READBACK_VERIFY_EN
            VF_ISSUE, VF_WAIT:          mem_address = cur;
`endif
            default:                    mem_address = '0;
        endcase
    end
endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: directed bursts from the test plan plus randomized bursts.
// The memory is modelled here; expected data comes from a word array updated per completed write.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_mem_access_master;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 1;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_init;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    mem_access_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_access_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Synchronous memory with RD_LAT-cycle registered read.
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5EED_0000 | 32'(i);
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
        end
        rd_pipe[0] <= mem[mem_address];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_out = rd_pipe[RD_LAT-1];

    // Reference contents: what the array must hold after the bursts so far.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wbuf [16];

    // Passive monitor: logs memory writes and counts pulses and illegal addresses.
    int                wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int                done_cnt  = 0;
    int                err_cnt   = 0;
    int                addr_viol = 0;
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            wr_addr_q.push_back(int'(mem_address));
            wr_data_q.push_back(mem_data_in);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
        if (!reset && int'(mem_address) >= DEPTH) addr_viol++;
    end

    function automatic logic [DATA_W-1:0] exp_word(input int a);
        logic [5:0] idx;
        idx = 6'(a % DEPTH);
        return ref_mem[idx];
    endfunction

    task automatic send_req(input logic wr, input int addr, input int len);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_len   = LEN_W'(len);
        @(negedge clk);
        check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
    endtask

    task automatic do_write(input int addr, input int len, input bit gaps);
        int beat = 0;
        int cyc  = 0;
        int d0   = done_cnt;
        int e0   = err_cnt;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_req(1'b1, addr, len);
        while (beat <= len && cyc < 200) begin
            bus.wdata_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.wdata       = bus.wdata_valid ? wbuf[beat] : $urandom;
            @(negedge clk);
            if (bus.wdata_valid && bus.wdata_ready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.wdata_valid = 1'b0;
        check_eq("wr_beats_taken", 32'(beat), 32'(len + 1));
        if (!gaps) check_eq("wr_cycles", 32'(cyc), 32'(len + 1));
        @(negedge clk);
        check_eq("wr_done_pulse", 32'(bus.done), 32'd1);
        check_eq("wr_we_count", 32'(wr_addr_q.size()), 32'(len + 1));
        for (int i = 0; i < wr_addr_q.size() && i <= len; i++) begin
            check_eq("wr_addr", 32'(wr_addr_q[i]), 32'((addr + i) % DEPTH));
            check_eq("wr_data", wr_data_q[i], wbuf[i]);
        end
        for (int i = 0; i <= len; i++) ref_mem[6'((addr + i) % DEPTH)] = wbuf[i];
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("wr_done_single", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check_eq("wr_done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("wr_no_err", 32'(err_cnt - e0), 32'd0);
    endtask

    task automatic do_read(input int addr, input int len, input int stall_beat,
                           input int stall_cyc, input bit rnd);
        int beat    = 0;
        int cyc     = 0;
        int stalled = 0;
        int d0      = done_cnt;
        int e0      = err_cnt;
        wr_addr_q.delete();
        send_req(1'b0, addr, len);
        while (beat <= len && cyc < 600) begin
            if (rnd)                                               bus.rdata_ready = 1'($urandom_range(0, 1));
            else if (beat == stall_beat && stalled < stall_cyc)   bus.rdata_ready = 1'b0;
            else                                                   bus.rdata_ready = 1'b1;
            @(negedge clk);
            if (bus.rdata_valid) begin
                check_eq("rd_data", bus.rdata, exp_word(addr + beat));
                check_eq("rd_last", 32'(bus.rdata_last), 32'(beat == len));
                if (bus.rdata_ready) beat++;
                else                 stalled++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rdata_ready = 1'b0;
        check_eq("rd_beats_taken", 32'(beat), 32'(len + 1));
        if (!rnd) check_eq("rd_cycles", 32'(cyc), 32'((len + 1) * (RD_LAT + 2) + stalled));
        if (!rnd && stall_cyc > 0) check_eq("rd_stall_len", 32'(stalled), 32'(stall_cyc));
        @(negedge clk);
        check_eq("rd_done_pulse", 32'(bus.done), 32'd1);
        check_eq("rd_no_write", 32'(wr_addr_q.size()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rd_done_single", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check_eq("rd_done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("rd_no_err", 32'(err_cnt - e0), 32'd0);
    endtask

    task automatic do_oob(input int addr, input int len);
        int d0 = done_cnt;
        int e0 = err_cnt;
        wr_addr_q.delete();
        send_req(1'($urandom_range(0, 1)), addr, len);
        @(negedge clk);
        check_eq("oob_done", 32'(bus.done), 32'd1);
        check_eq("oob_err", 32'(bus.err), 32'd1);
        check_eq("oob_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("oob_err_single", 32'(bus.err), 32'd0);
        check_eq("oob_req_ready2", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("oob_no_write", 32'(wr_addr_q.size()), 32'd0);
        check_eq("oob_done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("oob_err_once", 32'(err_cnt - e0), 32'd1);
    endtask

    // Reset lands while beat 3 of a 4-beat write is being offered.
    task automatic do_reset_mid_write(input int addr);
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_req(1'b1, addr, 3);
        for (int b = 0; b < 2; b++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wbuf[b];
            @(posedge clk); #1;
        end
        bus.wdata = wbuf[2];
        reset     = 1'b1;
        @(posedge clk); #1;
        reset           = 1'b0;
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_we", 32'(mem_write_enable), 32'd0);
        check_eq("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("rst_we_count", 32'(wr_addr_q.size()), 32'd2);
        for (int i = 0; i < 2; i++) ref_mem[6'((addr + i) % DEPTH)] = wbuf[i];
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h5EED_0000 | 32'(i);
        reset           = 1'b1;
        mem_init        = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("rst_state_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_state_wdata_ready", 32'(bus.wdata_ready), 32'd0);
        check_eq("rst_state_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        check_eq("rst_state_rdata_last", 32'(bus.rdata_last), 32'd0);
        check_eq("rst_state_rdata", bus.rdata, 32'd0);
        check_eq("rst_state_done", 32'(bus.done), 32'd0);
        check_eq("rst_state_err", 32'(bus.err), 32'd0);
        check_eq("rst_state_we", 32'(mem_write_enable), 32'd0);
        check_eq("rst_state_addr", 32'(mem_address), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0001 + 32'(i);
        do_write(5, 3, 1'b0);
        do_read(5, 3, 99, 0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        do_write(62, 3, 1'b0);
        do_read(62, 3, 99, 0, 1'b0);

        do_read(5, 3, 1, 5, 1'b0);
        do_oob(200, 2);
        do_read(7, 0, 99, 0, 1'b0);

        do_reset_mid_write(20);
        do_read(20, 3, 99, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int a;
            int l;
            a = $urandom_range(0, 79);
            l = $urandom_range(0, 15);
            if (a >= DEPTH) begin
                do_oob(a, l);
            end else if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
                do_write(a, l, 1'b1);
            end else begin
                do_read(a, l, 99, 0, 1'b1);
            end
        end

        check_eq("addr_range", 32'(addr_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
